apb_regfile: RTL and testbench
==============================

APB_REGFILE -- requirements
Module: apb_regfile

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, APB address width.
REQ-002 SHALL have parameter DWIDTH, default 8, data width of every register.
REQ-003 SHALL have parameter REGWN, default 5, number of read/write registers, range 1..16.
REQ-004 SHALL have parameter REGRN, default 3, number of read-only registers, range 1..16.
REQ-005 SHALL have parameter REGR_ADDR_OFFSET, default 5, address of read-only register 0; elaboration SHALL fail if REGR_ADDR_OFFSET < REGWN or REGR_ADDR_OFFSET+REGRN > 2**AWIDTH.
REQ-006 SHALL have parameter WAIT_STATES, default 0, PREADY-low cycles inserted per access, range 0..15.
REQ-007 SHALL have parameter RESET_VAL, default 0, reset value of every read/write register.
REQ-008 SHALL have ports, clock and reset first:
  PCLK  input  1  single clock; all state updates on rising edge.
  PRESET  input  1  reset, synchronous, active-high.
  PSEL  input  1  APB select.
  PENABLE  input  1  APB access phase.
  PWRITE  input  1  1 = write, 0 = read.
  PADDR  input  AWIDTH  word address.
  PWDATA  input  DWIDTH  write data.
  PRDATA  output  DWIDTH  read data, registered.
  PREADY  output  1  transfer completion, registered.
  PSLVERR  output  1  transfer error, registered.
  regr_in  input  REGRN*DWIDTH  read-only sources, register i at bits [i*DWIDTH +: DWIDTH].
  regw_out  output  REGWN*DWIDTH  read/write register contents, same packing.
  regw_wr  output  REGWN  one-cycle pulse per register on committed write.
  err_cnt  output  8  saturating count of PSLVERR responses.

Function
REQ-009 SHALL implement FSM IDLE, WAIT, RESP.
REQ-010 IDLE: on PSEL=1, PENABLE=0 SHALL capture PADDR, PWRITE, PWDATA; go RESP if WAIT_STATES=0, else WAIT with wait counter loaded with WAIT_STATES-1.
REQ-011 WAIT: SHALL hold PREADY=0; decrement counter each cycle; go RESP when counter=0.
REQ-012 RESP: SHALL drive PREADY=1 for exactly one cycle, then return to IDLE.
REQ-013 Access latency SHALL be WAIT_STATES+1 cycles after the setup cycle; zero-wait transfers SHALL complete in the first PENABLE cycle.
REQ-014 If PSEL=0 while in WAIT, SHALL abort to IDLE with no register update, no regw_wr pulse, no error count.
REQ-015 Address decode: 0..REGWN-1 selects read/write register; REGR_ADDR_OFFSET..REGR_ADDR_OFFSET+REGRN-1 selects read-only register; any other address is unmapped.
REQ-016 Valid write to read/write register k SHALL update regw_out[k] at the edge ending the RESP cycle and pulse regw_wr[k] in the following cycle, aligned with the new value.
REQ-017 Read of read/write register SHALL return current regw_out[k]; read of read-only register SHALL return regr_in sampled on the edge entering RESP.
REQ-018 PSLVERR=1 in RESP for unmapped address (read or write) and for write to read-only address; such writes SHALL change no state except err_cnt.
REQ-019 PRDATA SHALL be 0 outside RESP, on writes, and on error responses.
REQ-020 PSLVERR SHALL be 0 outside RESP.
REQ-021 err_cnt SHALL increment by 1 at end of each error RESP, saturating at 255.
REQ-022 Back-to-back transfers (new setup cycle immediately after RESP) SHALL be accepted without idle cycle.

Reset
REQ-023 PRESET=1 at a rising edge SHALL force IDLE, regw_out all RESET_VAL, PRDATA=0, PREADY=0, PSLVERR=0, regw_wr=0, err_cnt=0, wait counter=0.
REQ-024 Reset during WAIT or RESP SHALL discard the transfer; no register write SHALL occur.

Verification
REQ-025 WAIT_STATES=0: write 0xA5 to addr 2 -> PREADY=1 in first PENABLE cycle, PSLVERR=0, regw_out reg2=0xA5, regw_wr=5'b00100 one cycle; read addr 2 -> PRDATA=0xA5.
REQ-026 WAIT_STATES=3: read addr 6 with regr_in reg1=0x3C -> PREADY low 3 access cycles, then 1 with PRDATA=0x3C.
REQ-027 Write 0xFF to addr 5 and read addr 9 -> PSLVERR=1, PRDATA=0, regw_out unchanged, err_cnt=2.
REQ-028 256+4 error transfers -> err_cnt holds 255.
REQ-029 WAIT_STATES=3, write addr 0, PRESET=1 during second WAIT cycle -> regw_out reg0=RESET_VAL, PREADY=0, FSM IDLE, no regw_wr pulse.
REQ-030 WAIT_STATES=2, write addr 1, PSEL dropped in WAIT -> no update, no pulse, err_cnt unchanged; next transfer completes normally.

Source files
------------

// File: rtl/apb_regfile.sv
// APB slave exposing a bank of read/write registers and a bank of read-only
// inputs, with configurable wait states and a saturating error counter.
module apb_regfile #(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 8,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5,
  parameter int WAIT_STATES      = 0,
  parameter int RESET_VAL        = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [REGRN*DWIDTH-1:0] regr_in,
  output logic [REGWN*DWIDTH-1:0] regw_out,
  output logic [REGWN-1:0]        regw_wr,
  output logic [7:0]              err_cnt
);

  if (REGR_ADDR_OFFSET < REGWN || REGR_ADDR_OFFSET + REGRN > 2**AWIDTH) begin : g_bad_map
    $error("apb_regfile: read-only window overlaps read/write bank or exceeds address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]        WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [DWIDTH-1:0] RST_VAL = DWIDTH'(RESET_VAL);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [AWIDTH-1:0]   addr_q;
  logic                write_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   prdata_q;
  logic                pready_q;
  logic                pslverr_q;
  logic [REGWN-1:0]    regw_wr_q;
  logic [7:0]          err_cnt_q;
  logic [DWIDTH-1:0]   regw_q [REGWN];

  logic [AWIDTH-1:0]   dec_addr;
  logic                dec_write;
  logic                rw_hit;
  logic                ro_hit;
  logic                resp_err;
  logic                enter_resp;
  logic [DWIDTH-1:0]   rd_val;
  logic [REGWN-1:0]    wr_hot;

  // Decode looks at the live bus in IDLE (zero-wait case) and at the captured
  // request otherwise, so response data is always formed on the edge entering RESP.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec_addr  = (state_q == S_IDLE) ? PADDR : addr_q;
    dec_write = (state_q == S_IDLE) ? PWRITE : write_q;
    rw_hit    = 1'b0;
    ro_hit    = 1'b0;
    rd_val    = '0;
    for (int k = 0; k < REGWN; k++) begin
      if (dec_addr == AWIDTH'(k)) begin
        rw_hit = 1'b1;
        rd_val = regw_q[k];
      end
    end
    for (int k = 0; k < REGRN; k++) begin
      if (dec_addr == AWIDTH'(REGR_ADDR_OFFSET + k)) begin
        ro_hit = 1'b1;
        rd_val = regr_in[k*DWIDTH +: DWIDTH];
      end
    end
    resp_err   = !(rw_hit || (ro_hit && !dec_write));
    enter_resp = ((state_q == S_IDLE) && PSEL && !PENABLE && (WAIT_STATES == 0)) ||
                 ((state_q == S_WAIT) && PSEL && (cnt_q == 4'd0));
  end

  always_comb begin
    wr_hot = '0;
    for (int k = 0; k < REGWN; k++) begin
      wr_hot[k] = write_q && (addr_q == AWIDTH'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      regw_wr_q <= '0;
      err_cnt_q <= '0;
      // NOTE: the register bank is reset because software relies on RESET_VAL;
      // it is a handful of flops, not a RAM macro.
      for (int k = 0; k < REGWN; k++) regw_q[k] <= RST_VAL;
    end else begin
      regw_wr_q <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL)                state_q <= S_IDLE;
          else if (cnt_q == 4'd0)   state_q <= S_RESP;
          else                      cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (pslverr_q) begin
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else if (write_q) begin
            for (int k = 0; k < REGWN; k++) begin
              if (wr_hot[k]) regw_q[k] <= wdata_q;
            end
            regw_wr_q <= wr_hot;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        pready_q  <= 1'b1;
        pslverr_q <= resp_err;
        prdata_q  <= (resp_err || dec_write) ? '0 : rd_val;
      end
    end
  end

  for (genvar g = 0; g < REGWN; g++) begin : g_out
    assign regw_out[g*DWIDTH +: DWIDTH] = regw_q[g];
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign regw_wr = regw_wr_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench for apb_regfile: three instances with 0, 3 and 2 wait states
// exercise access, latency, errors, saturation, reset and abort behaviour.
module tb_apb_regfile;

  logic        clk = 1'b0;
  logic        preset  [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [3:0]  paddr   [3];
  logic [7:0]  pwdata  [3];
  logic [7:0]  prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [23:0] regr_in [3];
  logic [39:0] regw_out[3];
  logic [4:0]  regw_wr [3];
  logic [7:0]  err_cnt [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_regfile #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .PCLK    (clk),
      .PRESET  (preset[g]),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g]),
      .regr_in (regr_in[g]),
      .regw_out(regw_out[g]),
      .regw_wr (regw_wr[g]),
      .err_cnt (err_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rw(input int d, input int k);
    return regw_out[d][k*8 +: 8];
  endfunction

  // Called at posedge+1 with the bus idle; returns at posedge+1 after the
  // edge that ends RESP, so consecutive calls are back-to-back transfers.
  task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic err, output int waits);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1 penable[d] = 1'b1;
    waits = 0;
    @(negedge clk);
    while (pready[d] !== 1'b1 && waits <= 40) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 40) check("xfer_timeout_pready", {39'd0, pready[d]}, 40'd1);
    rd  = prdata[d];
    err = pslverr[d];
    @(posedge clk); #1 psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    int         w;
    logic       any_rdy;
    logic [4:0] any_wr;

    for (int d = 0; d < 3; d++) begin
      preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
    end
    regr_in[0] = 24'hC3_96_11;
    regr_in[1] = 24'h00_3C_00;
    regr_in[2] = 24'h55_44_33;
    repeat (2) @(posedge clk);
    #1 for (int d = 0; d < 3; d++) preset[d] = 1'b0;

    @(negedge clk);
    check("rst_pready",  {39'd0, pready[0]},  40'd0);
    check("rst_pslverr", {39'd0, pslverr[0]}, 40'd0);
    check("rst_prdata",  {32'd0, prdata[0]},  40'd0);
    check("rst_regw",    regw_out[0],         40'd0);
    check("rst_regw_wr", {35'd0, regw_wr[0]}, 40'd0);
    check("rst_err_cnt", {32'd0, err_cnt[0]}, 40'd0);
    @(posedge clk); #1;

    // Zero-wait write, pulse timing and readback
    xfer(0, 1'b1, 4'd2, 8'hA5, rd, err, w);
    check("w2_waits", 40'(w), 40'd0);
    check("w2_err",   {39'd0, err}, 40'd0);
    check("w2_prdata_on_write", {32'd0, rd}, 40'd0);
    @(negedge clk);
    check("w2_pulse", {35'd0, regw_wr[0]}, 40'b00100);
    check("w2_value", {32'd0, rw(0, 2)},   40'hA5);
    @(negedge clk);
    check("w2_pulse_gone", {35'd0, regw_wr[0]}, 40'd0);
    check("idle_pslverr",  {39'd0, pslverr[0]}, 40'd0);
    check("idle_prdata",   {32'd0, prdata[0]},  40'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 4'd2, 8'h00, rd, err, w);
    check("r2_data",  {32'd0, rd}, 40'hA5);
    check("r2_waits", 40'(w), 40'd0);

    // Back-to-back: top read/write register, then read-only window edges
    xfer(0, 1'b1, 4'd4, 8'h3E, rd, err, w);
    xfer(0, 1'b0, 4'd4, 8'h00, rd, err, w);
    check("b2b_r4_data",  {32'd0, rd}, 40'h3E);
    check("b2b_r4_waits", 40'(w), 40'd0);
    xfer(0, 1'b0, 4'd0, 8'h00, rd, err, w);
    check("r0_reset_val", {32'd0, rd}, 40'h00);
    xfer(0, 1'b0, 4'd5, 8'h00, rd, err, w);
    check("ro0_data", {32'd0, rd}, 40'h11);
    check("ro0_err",  {39'd0, err}, 40'd0);
    xfer(0, 1'b0, 4'd7, 8'h00, rd, err, w);
    check("ro2_data", {32'd0, rd}, 40'hC3);

    // Error responses
    xfer(0, 1'b1, 4'd5, 8'hFF, rd, err, w);
    check("wro_err",  {39'd0, err}, 40'd1);
    check("wro_data", {32'd0, rd},  40'd0);
    xfer(0, 1'b0, 4'd9, 8'h00, rd, err, w);
    check("r9_err",  {39'd0, err}, 40'd1);
    check("r9_data", {32'd0, rd},  40'd0);
    check("err_regw_unchanged", regw_out[0], 40'h3E_00_A5_00_00);
    check("err_cnt_2", {32'd0, err_cnt[0]}, 40'd2);
    xfer(0, 1'b1, 4'd8, 8'h77, rd, err, w);
    check("w8_unmapped_err", {39'd0, err}, 40'd1);

    // Saturation: 3 errors so far, 252 more reach 255, then 5 past it
    for (int i = 0; i < 252; i++) xfer(0, i[0], i[0] ? 4'd6 : 4'd15, 8'h5A, rd, err, w);
    check("err_cnt_255", {32'd0, err_cnt[0]}, 40'd255);
    for (int i = 0; i < 5; i++) xfer(0, 1'b0, 4'd12, 8'h00, rd, err, w);
    check("err_cnt_sat", {32'd0, err_cnt[0]}, 40'd255);
    check("sat_regw_unchanged", regw_out[0], 40'h3E_00_A5_00_00);

    // Three wait states: read-only register 1
    @(posedge clk); #1;
    xfer(1, 1'b0, 4'd6, 8'h00, rd, err, w);
    check("ws3_waits", 40'(w), 40'd3);
    check("ws3_data",  {32'd0, rd}, 40'h3C);

    // Reset during the second WAIT cycle discards the write
    xfer(1, 1'b1, 4'd0, 8'h77, rd, err, w);
    check("ws3_w0_waits", 40'(w), 40'd3);
    @(negedge clk);
    check("ws3_w0_value", {32'd0, rw(1, 0)}, 40'h77);
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 4'd0; pwdata[1] = 8'h99;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 preset[1] = 1'b1;
    @(posedge clk); #1 preset[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    any_rdy = 1'b0; any_wr = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_rdy |= pready[1];
      any_wr  |= regw_wr[1];
    end
    check("rst_mid_pready", {39'd0, any_rdy}, 40'd0);
    check("rst_mid_pulse",  {35'd0, any_wr},  40'd0);
    check("rst_mid_reg0",   {32'd0, rw(1, 0)}, 40'h00);
    @(posedge clk); #1;
    xfer(1, 1'b0, 4'd0, 8'h00, rd, err, w);
    check("rst_mid_next_waits", 40'(w), 40'd3);
    check("rst_mid_next_data",  {32'd0, rd}, 40'h00);

    // Two wait states: abort by dropping PSEL in WAIT
    xfer(2, 1'b1, 4'd1, 8'h12, rd, err, w);
    check("ws2_waits", 40'(w), 40'd2);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 4'd1; pwdata[2] = 8'hEE;
    @(posedge clk); #1 penable[2] = 1'b1;
    @(posedge clk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
    any_rdy = 1'b0; any_wr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_rdy |= pready[2];
      any_wr  |= regw_wr[2];
    end
    check("abort_pready",  {39'd0, any_rdy}, 40'd0);
    check("abort_pulse",   {35'd0, any_wr},  40'd0);
    check("abort_reg1",    {32'd0, rw(2, 1)}, 40'h12);
    check("abort_err_cnt", {32'd0, err_cnt[2]}, 40'd0);
    @(posedge clk); #1;
    xfer(2, 1'b1, 4'd1, 8'h34, rd, err, w);
    check("after_abort_waits", 40'(w), 40'd2);
    check("after_abort_err",   {39'd0, err}, 40'd0);
    @(negedge clk);
    check("after_abort_pulse", {35'd0, regw_wr[2]}, 40'b00010);
    check("after_abort_reg1",  {32'd0, rw(2, 1)},   40'h34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
